imem_loader: RTL and testbench

//  Upstream boot stage for the single-cycle RV32 core: consumes a byte stream (UART/host FIFO), assembles

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: assembles a framed little-endian byte stream into 32-bit words for the core's
// instruction memory and holds the core in reset until the image is loaded.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned IMEM_DEPTH = 512,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   output logic             rx_ready,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_data,
   output logic             cpu_reset,
   output logic             load_done,
   output logic             load_error
);

   localparam int unsigned ADDR_W = $clog2(IMEM_DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StLenLo,
      StLenHi,
      StData,
`ifdef LOADER_CHECKSUM_EN
      StCsum,
`endif
      StDone,
      StErr
   } state_e;

`ifdef LOADER_CHECKSUM_EN
   localparam state_e StFinal = StCsum;
`else
   localparam state_e StFinal = StDone;
`endif

   state_e            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W:0]   word_q, word_d;
   logic [1:0]        byte_q, byte_d;
   logic [23:0]       shift_q, shift_d;
   logic              we_d;
   logic [WIDTH-1:0]  addr_d, data_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      word_d  = word_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      we_d    = 1'b0;
      addr_d  = mem_addr;
      data_d  = mem_data;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      if (rx_valid && rx_ready) begin
         unique case (state_q)
            StIdle: if (rx_data == SYNC_BYTE) state_d = StLenLo;
            StLenLo: begin
               len_d   = {8'h00, rx_data};
               state_d = StLenHi;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = rx_data;
`endif
            end
            StLenHi: begin
               len_d  = {rx_data, len_q[7:0]};
               word_d = '0;
               byte_d = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               if (len_d == 16'd0)                 state_d = StFinal;
               else if (32'(len_d) > IMEM_DEPTH)   state_d = StErr;
               else                                state_d = StData;
            end
            StData: begin
               byte_d = byte_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               case (byte_q)
                  2'd0:    shift_d[7:0]   = rx_data;
                  2'd1:    shift_d[15:8]  = rx_data;
                  2'd2:    shift_d[23:16] = rx_data;
                  default: begin
                     // Fourth byte completes the word; issue the write directly.
                     we_d   = 1'b1;
                     addr_d = WIDTH'(word_q);
                     data_d = WIDTH'({rx_data, shift_q});
                     word_d = word_q + 1'b1;
                     if (16'(word_d) == len_q) state_d = StFinal;
                  end
               endcase
            end
`ifdef LOADER_CHECKSUM_EN
            StCsum: state_d = (csum_q == rx_data) ? StDone : StErr;
`endif
            StDone: if (rx_data == SYNC_BYTE) state_d = StLenLo;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         len_q      <= '0;
         word_q     <= '0;
         byte_q     <= '0;
         shift_q    <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         rx_ready   <= 1'b1;
         cpu_reset  <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_q     <= word_d;
         byte_q     <= byte_d;
         shift_q    <= shift_d;
         mem_we     <= we_d;
         mem_addr   <= addr_d;
         mem_data   <= data_d;
         // Status flags follow the next state so they line up with it.
         rx_ready   <= (state_d != StErr);
         cpu_reset  <= (state_d != StDone);
         load_done  <= (state_d == StDone);
         load_error <= (state_d == StErr);
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are built from word lists, expected writes queued
// and checked on every write cycle; status flags checked after each frame.
module tb_imem_loader;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready, mem_we, cpu_reset, load_done, load_error;
   logic [31:0] mem_addr, mem_data;

   imem_loader dut (
      .clock      (clock),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clock = ~clock;

   int          total = 0;
   int          bad = 0;
   logic [63:0] exp_q[$];
   logic [31:0] wbuf[$];
   logic [7:0]  fbytes[$];
   bit          loading = 1'b0;
   bit          prev_we = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Every write must match the next queued (addr,data), never back-to-back.
   always @(negedge clock) begin
      if (reset) prev_we = 1'b0;
      else begin
         if (mem_we) begin
            check("we_spacing", 32'(prev_we), 32'd0);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr %h data %h want no write", mem_addr, mem_data);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               check("wr_addr", mem_addr, e[63:32]);
               check("wr_data", mem_data, e[31:0]);
            end
         end
         if (loading) check("cpu_reset_hold", 32'(cpu_reset), 32'd1);
         prev_we = mem_we;
      end
   end

   task automatic send_byte(input logic [7:0] b, output bit acc);
      rx_valid = 1'b1;
      rx_data  = b;
      acc      = rx_ready;
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   task automatic gap(input bit gaps);
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
   endtask

   // Frame bytes from wbuf: sync, length LSB first, words LSB first, optional checksum.
   task automatic build_frame(input int cut);
      int n;
      int nd;
      logic [7:0] cs;
      n  = wbuf.size();
      nd = (cut < 0) ? 4 * n : cut;
      fbytes.delete();
      fbytes.push_back(8'hA5);
      fbytes.push_back(n[7:0]);
      fbytes.push_back(n[15:8]);
      cs = n[7:0] ^ n[15:8];
      for (int i = 0; i < nd; i++) begin
         logic [31:0] w;
         w = wbuf[i / 4];
         fbytes.push_back(w[8 * (i % 4) +: 8]);
         cs ^= w[8 * (i % 4) +: 8];
      end
`ifdef LOADER_CHECKSUM_EN
      if (cut < 0) fbytes.push_back(cs);
`endif
      for (int i = 0; i < nd / 4; i++) exp_q.push_back({32'(i), wbuf[i]});
   endtask

   task automatic send_frame(input bit gaps, input int cut);
      bit acc;
      int last;
      build_frame(cut);
      last = (cut < 0) ? fbytes.size() - 1 : -1;
      for (int k = 0; k < fbytes.size(); k++) begin
         gap(gaps);
         if (k == last) loading = 1'b0;
         send_byte(fbytes[k], acc);
         check("byte_accepted", 32'(acc), 32'd1);
         if (k == 0 && k != last) loading = 1'b1;
      end
      if (cut < 0) begin
         check("cpu_reset_released", 32'(cpu_reset), 32'd0);
         check("load_done", 32'(load_done), 32'd1);
         check("load_error_clear", 32'(load_error), 32'd0);
         check("rx_ready_done", 32'(rx_ready), 32'd1);
         @(negedge clock);
         check("writes_all_seen", 32'(exp_q.size()), 32'd0);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      loading = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_data", mem_data, 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_load_error", 32'(load_error), 32'd0);
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      exp_q.delete();
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic send_garbage(input int cnt);
      bit acc;
      for (int i = 0; i < cnt; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h5A;
         send_byte(b, acc);
      end
   endtask

   task automatic case1_words();
      wbuf.delete();
      wbuf.push_back(32'h0000_0013);
      wbuf.push_back(32'h0010_0093);
   endtask

   initial begin
      bit acc;
      logic [7:0] lit1[11];
      lit1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

      @(negedge clock);
      do_reset();

      // Case 1, with the model's byte stream pinned to the literal frame.
      case1_words();
      build_frame(-1);
      exp_q.delete();
      for (int i = 0; i < 11; i++) check("pin_frame_byte", 32'(fbytes[i]), 32'(lit1[i]));
`ifdef LOADER_CHECKSUM_EN
      check("pin_csum", 32'(fbytes[11]), 32'h92);
`endif
      send_frame(1'b0, -1);

      // Case 2: empty image.
      wbuf.delete();
      send_frame(1'b0, -1);

      // Case 4: leading garbage from IDLE, random gaps.
      do_reset();
      send_byte(8'hFF, acc);
      send_byte(8'h3C, acc);
      case1_words();
      send_frame(1'b1, -1);

      // Case 5: reset mid-word, then reload from address 0.
      wbuf.delete();
      for (int i = 0; i < 3; i++) wbuf.push_back($urandom);
      send_frame(1'b0, 9);
      repeat (2) @(negedge clock);
      check("partial_writes_seen", 32'(exp_q.size()), 32'd0);
      do_reset();
      case1_words();
      send_frame(1'b0, -1);

      // Random frames, with non-sync garbage ignored in DONE between them.
      for (int f = 0; f < 8; f++) begin
         send_garbage($urandom_range(0, 3));
         check("done_after_garbage", 32'(load_done), 32'd1);
         wbuf.delete();
         for (int i = 0; i < $urandom_range(1, 6); i++) wbuf.push_back($urandom);
         send_frame(f[0], -1);
      end

      // Largest image fills addresses 0..511.
      wbuf.delete();
      for (int i = 0; i < 512; i++) wbuf.push_back($urandom);
      send_frame(1'b0, -1);

`ifdef LOADER_CHECKSUM_EN
      // Case 6: wrong checksum.
      case1_words();
      build_frame(-1);
      fbytes[fbytes.size() - 1] = 8'h00;
      for (int k = 0; k < fbytes.size(); k++) send_byte(fbytes[k], acc);
      check("csum_err", 32'(load_error), 32'd1);
      check("csum_err_cpu_reset", 32'(cpu_reset), 32'd1);
      repeat (2) @(negedge clock);
      check("csum_writes_seen", 32'(exp_q.size()), 32'd0);
      do_reset();
`endif

      // Case 3: N=513 is rejected and the error is sticky.
      send_byte(8'hA5, acc);
      send_byte(8'h01, acc);
      send_byte(8'h02, acc);
      check("err_flag", 32'(load_error), 32'd1);
      check("err_cpu_reset", 32'(cpu_reset), 32'd1);
      check("err_rx_ready", 32'(rx_ready), 32'd0);
      check("err_not_done", 32'(load_done), 32'd0);
      send_byte(8'hA5, acc);
      check("err_refuses_byte", 32'(acc), 32'd0);
      repeat (5) @(negedge clock);
      check("err_sticky", 32'(load_error), 32'd1);
      do_reset();

      // Back to normal after the error.
      case1_words();
      send_frame(1'b1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
